phase_timer: RTL and testbench
==============================

# phase_timer

Parametrised multi-phase countdown timer for the traffic controller. It holds a programmable duration for each signal phase and divides the system clock into timer ticks. It counts the active phase down to zero, then advances to the next phase in round-robin order and reloads that phase's duration. It replaces the single-duration down-counter and its fixed decrement delay with a cycle-accurate prescaler, hold, forced advance and runtime-writable duration table.

## Interface
- WIDTH, 5: bit width of durations and of the count.
- PHASES, 4: number of phases, minimum 2. PW = max(1, clog2(PHASES)).
- PRESCALE, 100000: clock cycles per timer tick, minimum 1.
- DEFAULT_DUR, 5'd10: reset value of every duration-table entry, WIDTH bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- hold  in  1  freezes the prescaler and count while high.
- force_next  in  1  ends the current phase immediately.
- load_en  in  1  writes load_val into the duration table at load_idx.
- load_idx  in  PW  table index to write; indices ≥ PHASES are ignored.
- load_val  in  WIDTH  new duration value.
- n  out  WIDTH  remaining count of the current phase.
- phase  out  PW  index of the current phase.
- tick  out  1  one-cycle pulse on each prescaler terminal count.
- expire  out  1  one-cycle pulse when a phase ends (natural or forced).

## Operation
- Reset, when high at an edge:
  - every table entry ← DEFAULT_DUR;
  - phase ← 0, n ← DEFAULT_DUR, prescaler ← 0;
  - tick ← 0, expire ← 0.
  - Overrides every other input.
- Prescaler counts 0 … PRESCALE-1 while hold=0, then wraps to 0. The edge at which it wraps is a tick edge.
  - With PRESCALE=1, every non-held edge is a tick edge.
- At a tick edge:
  - if n ≠ 0, n ← n-1;
  - if n = 0, the phase expires.
  - A phase therefore lasts dur+1 ticks; dur=0 gives a one-tick phase.
- Expire action:
  - phase ← (phase = PHASES-1) ? 0 : phase+1;
  - n ← table[new phase];
  - expire ← 1 for that cycle.
- force_next=1 (not in reset):
  - performs the expire action at that edge, regardless of n and of hold;
  - clears the prescaler to 0;
  - no tick is produced that edge.
- Priority: reset > force_next > tick decrement/expire. A tick edge coinciding with force_next is discarded.
- hold=1:
  - prescaler and n frozen; tick and expire stay 0, unless force_next is asserted.
  - Releasing hold resumes from the frozen prescaler value.
- Table write (load_en=1), independent of counting:
  - does not alter n of the running phase, even when load_idx = phase;
  - takes effect on the next reload of that index.
  - Write-through: if the write targets the index being reloaded at the same edge, the reload uses load_val.
- Arithmetic is unsigned WIDTH bits. n never wraps below 0, because 0 always triggers a reload instead of a decrement.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- tick and expire are high in the cycle following the edge that caused them, together with the updated n and phase.
- Reset latency: outputs show reset values in the first cycle after the reset edge.
- Forced-advance latency: the edge sampling force_next=1 updates phase and n. expire is visible in the following cycle.
- Tick period: PRESCALE cycles from reset release or forced advance, excluding held cycles.
- Reset asserted mid-phase, mid-prescale or mid-hold returns to the reset state at the next edge; no pending tick survives.

## Test plan
All scenarios use PRESCALE=4, WIDTH=5, PHASES=3, DEFAULT_DUR=2.
- Reset then free-run:
  - tick every 4th cycle;
  - n goes 2,1,0 → expire with phase=1, n=2;
  - phase sequence 0,1,2,0, each lasting 12 cycles.
- Load table[1]=0 while in phase 0:
  - phase 0 unchanged (n 2,1,0);
  - phase 1 lasts one tick (4 cycles), then phase 2 with n=2.
- Write-through: write table[1]=7 on the same edge as the phase-0 expiry → phase=1, n=7. Writing table[0]=9 while in phase 0 leaves n unchanged.
- Hold for 10 cycles at n=1 with prescaler=2:
  - n and prescaler unchanged, no tick during hold;
  - after release, the next tick occurs 2 cycles later.
- force_next at n=2, prescaler=3 (a tick edge):
  - phase advances, n=table[next], expire pulses, tick stays 0;
  - the next tick occurs 4 cycles later.
- Reset asserted mid-phase 2 with hold=1 and force_next=1 → next cycle phase=0, n=2, table restored to 2, tick=0, expire=0.

Source files
------------

// File: rtl/phase_timer.sv
// phase_timer: multi-phase round-robin countdown timer.
// A prescaler divides clk into timer ticks; each tick counts the active
// phase down, and a phase at zero (or a forced advance) moves to the next
// phase and reloads its duration from a runtime-writable table.
module phase_timer #(
  parameter int unsigned          WIDTH       = 5,
  parameter int unsigned          PHASES      = 4,
  parameter int unsigned          PRESCALE    = 100000,
  parameter logic [WIDTH-1:0]     DEFAULT_DUR = 5'd10,
  localparam int unsigned         PW          = (PHASES > 2) ? $clog2(PHASES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             force_next,
  input  logic             load_en,
  input  logic [PW-1:0]    load_idx,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] n,
  output logic [PW-1:0]    phase,
  output logic             tick,
  output logic             expire
);

  localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSW-1:0]   presc_q, presc_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             tick_q, tick_d;
  logic             expire_q, expire_d;
  logic [WIDTH-1:0] dur_q [PHASES];

  logic             tick_edge;
  logic             expire_now;
  logic             table_wr;
  logic [PW-1:0]    next_phase;
  logic [WIDTH-1:0] reload_val;

  // Next-state logic: forced advance outranks the tick, and a write landing
  // on the index being reloaded is forwarded straight into n.
  always_comb begin
    tick_edge  = !hold && (presc_q == PSW'(PRESCALE - 1));
    expire_now = force_next || (tick_edge && (n_q == '0));
    table_wr   = load_en && (32'(load_idx) < PHASES);
    next_phase = (phase_q == PW'(PHASES - 1)) ? '0 : phase_q + PW'(1);
    reload_val = (load_en && (load_idx == next_phase)) ? load_val
                                                       : dur_q[next_phase];

    presc_d  = presc_q;
    n_d      = n_q;
    phase_d  = phase_q;
    tick_d   = 1'b0;
    expire_d = 1'b0;

    if (force_next) begin
      presc_d = '0;
    end else if (!hold) begin
      presc_d = tick_edge ? '0 : presc_q + PSW'(1);
      tick_d  = tick_edge;
    end

    if (expire_now) begin
      phase_d  = next_phase;
      n_d      = reload_val;
      expire_d = 1'b1;
    end else if (tick_edge) begin
      n_d = n_q - WIDTH'(1);
    end
  end

  // Counter, phase and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      n_q      <= DEFAULT_DUR;
      phase_q  <= '0;
      tick_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      n_q      <= n_d;
      phase_q  <= phase_d;
      tick_q   <= tick_d;
      expire_q <= expire_d;
    end
  end

  // Duration table: reset to the default, written independently of counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PHASES; i++) begin
        dur_q[i] <= DEFAULT_DUR;
      end
    end else if (table_wr) begin
      dur_q[load_idx] <= load_val;
    end
  end

  assign n      = n_q;
  assign phase  = phase_q;
  assign tick   = tick_q;
  assign expire = expire_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed testbench for phase_timer (PRESCALE=4, WIDTH=5, PHASES=3, DEFAULT_DUR=2).
module tb_phase_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold;
  logic       force_next;
  logic       load_en;
  logic [1:0] load_idx;
  logic [4:0] load_val;
  logic [4:0] n;
  logic [1:0] phase;
  logic       tick;
  logic       expire;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  phase_timer #(
    .WIDTH(5),
    .PHASES(3),
    .PRESCALE(4),
    .DEFAULT_DUR(5'd2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hold(hold),
    .force_next(force_next),
    .load_en(load_en),
    .load_idx(load_idx),
    .load_val(load_val),
    .n(n),
    .phase(phase),
    .tick(tick),
    .expire(expire)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; hold = 1'b0; force_next = 1'b0; load_en = 1'b0;
    load_idx = '0; load_val = '0;
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b1; force_next = 1'b1; load_en = 1'b1;
    load_idx = 2'd0; load_val = 5'd17;
    step();
    checks++;
    if ({phase, n, tick, expire} !== {2'd0, 5'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: phase=%0d n=%0d tick=%0b expire=%0b, want phase=0 n=2 tick=0 expire=0",
               phase, n, tick, expire);
    end
    do_reset();
  endtask

  task automatic test_free_run();
    logic       e_tick, e_exp;
    logic [1:0] e_ph;
    logic [4:0] e_n;
    do_reset();
    for (int c = 1; c <= 36; c++) begin
      step();
      e_tick = (c % 4 == 0);
      e_exp  = (c % 12 == 0);
      e_ph   = 2'((c / 12) % 3);
      e_n    = 5'(2 - ((c % 12) / 4));
      checks++;
      if ({tick, expire, phase, n} !== {e_tick, e_exp, e_ph, e_n}) begin
        failures++;
        $display("FAIL free_run c=%0d: tick=%0b expire=%0b phase=%0d n=%0d, want tick=%0b expire=%0b phase=%0d n=%0d",
                 c, tick, expire, phase, n, e_tick, e_exp, e_ph, e_n);
      end
    end
  endtask

  task automatic test_load_short();
    do_reset();
    load_en = 1'b1; load_idx = 2'd1; load_val = 5'd0;
    step();
    load_en = 1'b0;
    while (cyc < 8) step();
    checks++;
    if ({phase, n} !== {2'd0, 5'd0}) begin
      failures++;
      $display("FAIL load_short_p0: phase=%0d n=%0d, want phase=0 n=0", phase, n);
    end
    while (cyc < 12) step();
    checks++;
    if ({phase, n, expire} !== {2'd1, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL load_short_p1: phase=%0d n=%0d expire=%0b, want phase=1 n=0 expire=1", phase, n, expire);
    end
    while (cyc < 15) step();
    checks++;
    if ({phase, expire} !== {2'd1, 1'b0}) begin
      failures++;
      $display("FAIL load_short_p1_hold: phase=%0d expire=%0b, want phase=1 expire=0", phase, expire);
    end
    step();
    checks++;
    if ({phase, n, expire} !== {2'd2, 5'd2, 1'b1}) begin
      failures++;
      $display("FAIL load_short_p2: phase=%0d n=%0d expire=%0b, want phase=2 n=2 expire=1", phase, n, expire);
    end
  endtask

  task automatic test_write_through();
    do_reset();
    step();
    load_en = 1'b1; load_idx = 2'd0; load_val = 5'd9;
    step();
    load_en = 1'b0;
    checks++;
    if ({phase, n} !== {2'd0, 5'd2}) begin
      failures++;
      $display("FAIL wt_running_unchanged: phase=%0d n=%0d, want phase=0 n=2", phase, n);
    end
    while (cyc < 11) step();
    load_en = 1'b1; load_idx = 2'd1; load_val = 5'd7;
    step();
    load_en = 1'b0;
    checks++;
    if ({phase, n, expire} !== {2'd1, 5'd7, 1'b1}) begin
      failures++;
      $display("FAIL wt_same_edge: phase=%0d n=%0d expire=%0b, want phase=1 n=7 expire=1", phase, n, expire);
    end
    while (cyc < 44) step();
    checks++;
    if ({phase, n, expire} !== {2'd2, 5'd2, 1'b1}) begin
      failures++;
      $display("FAIL wt_p2_entry: phase=%0d n=%0d expire=%0b, want phase=2 n=2 expire=1", phase, n, expire);
    end
    while (cyc < 56) step();
    checks++;
    if ({phase, n, expire} !== {2'd0, 5'd9, 1'b1}) begin
      failures++;
      $display("FAIL wt_p0_reload: phase=%0d n=%0d expire=%0b, want phase=0 n=9 expire=1", phase, n, expire);
    end
  endtask

  task automatic test_hold();
    do_reset();
    while (cyc < 6) step();
    checks++;
    if ({phase, n, tick} !== {2'd0, 5'd1, 1'b0}) begin
      failures++;
      $display("FAIL hold_pre: phase=%0d n=%0d tick=%0b, want phase=0 n=1 tick=0", phase, n, tick);
    end
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({n, tick, expire} !== {5'd1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold_frozen i=%0d: n=%0d tick=%0b expire=%0b, want n=1 tick=0 expire=0", i, n, tick, expire);
      end
    end
    hold = 1'b0;
    step();
    checks++;
    if ({n, tick} !== {5'd1, 1'b0}) begin
      failures++;
      $display("FAIL hold_release1: n=%0d tick=%0b, want n=1 tick=0", n, tick);
    end
    step();
    checks++;
    if ({n, tick} !== {5'd0, 1'b1}) begin
      failures++;
      $display("FAIL hold_release2: n=%0d tick=%0b, want n=0 tick=1", n, tick);
    end
  endtask

  task automatic test_force();
    do_reset();
    while (cyc < 3) step();
    force_next = 1'b1;
    step();
    force_next = 1'b0;
    checks++;
    if ({phase, n, expire, tick} !== {2'd1, 5'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL force_tick_edge: phase=%0d n=%0d expire=%0b tick=%0b, want phase=1 n=2 expire=1 tick=0",
               phase, n, expire, tick);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if ({tick, expire} !== 2'b00) begin
        failures++;
        $display("FAIL force_gap i=%0d: tick=%0b expire=%0b, want tick=0 expire=0", i, tick, expire);
      end
    end
    step();
    checks++;
    if ({tick, n, phase} !== {1'b1, 5'd1, 2'd1}) begin
      failures++;
      $display("FAIL force_next_tick: tick=%0b n=%0d phase=%0d, want tick=1 n=1 phase=1", tick, n, phase);
    end
    hold = 1'b1; force_next = 1'b1;
    step();
    force_next = 1'b0;
    checks++;
    if ({phase, n, expire, tick} !== {2'd2, 5'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL force_in_hold: phase=%0d n=%0d expire=%0b tick=%0b, want phase=2 n=2 expire=1 tick=0",
               phase, n, expire, tick);
    end
    step();
    checks++;
    if ({phase, expire} !== {2'd2, 1'b0}) begin
      failures++;
      $display("FAIL force_hold_after: phase=%0d expire=%0b, want phase=2 expire=0", phase, expire);
    end
    force_next = 1'b1;
    step();
    force_next = 1'b0; hold = 1'b0;
    checks++;
    if ({phase, n, expire} !== {2'd0, 5'd2, 1'b1}) begin
      failures++;
      $display("FAIL force_wrap: phase=%0d n=%0d expire=%0b, want phase=0 n=2 expire=1", phase, n, expire);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_en = 1'b1; load_idx = 2'd0; load_val = 5'd5;
    step();
    load_en = 1'b0;
    while (cyc < 26) step();
    checks++;
    if (phase !== 2'd2) begin
      failures++;
      $display("FAIL reset_mid_pre: phase=%0d, want phase=2", phase);
    end
    reset = 1'b1; hold = 1'b1; force_next = 1'b1;
    step();
    reset = 1'b0; hold = 1'b0; force_next = 1'b0;
    checks++;
    if ({phase, n, tick, expire} !== {2'd0, 5'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: phase=%0d n=%0d tick=%0b expire=%0b, want phase=0 n=2 tick=0 expire=0",
               phase, n, tick, expire);
    end
    force_next = 1'b1;
    step(); step(); step();
    force_next = 1'b0;
    checks++;
    if ({phase, n} !== {2'd0, 5'd2}) begin
      failures++;
      $display("FAIL reset_table_restored: phase=%0d n=%0d, want phase=0 n=2", phase, n);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_short();
    test_write_through();
    test_hold();
    test_force();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
